// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light phase controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2,
    FLASH  = 2'd3
  } phase_t;

  // Bit positions shared by the one-hot counter load and the lamp vector
  localparam int pGREEN_IDX  = 0;
  localparam int pYELLOW_IDX = 1;
  localparam int pRED_IDX    = 2;

  localparam logic [2:0] LOAD_NONE   = 3'b000;
  localparam logic [2:0] LOAD_GREEN  = 3'b001;
  localparam logic [2:0] LOAD_YELLOW = 3'b010;
  localparam logic [2:0] LOAD_RED    = 3'b100;

  localparam logic [2:0] LAMP_OFF    = 3'b000;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  // Lamp drive {red, yellow, green} for a given phase; FLASH shows yellow only when flash is set
  function automatic logic [2:0] lamp_code(input phase_t s, input logic flash);
    logic [2:0] code;
    code = LAMP_OFF;
    case (s)
      GREEN:   code = LAMP_GREEN;
      YELLOW:  code = LAMP_YELLOW;
      RED:     code = LAMP_RED;
      default: code[pYELLOW_IDX] = flash;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every pTICK_DIV clocks.
module tick_prescaler #(
  parameter int pTICK_DIV  = 50_000_000,
  parameter int pDIV_WIDTH = 26
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [pDIV_WIDTH-1:0] DIV_LAST = pDIV_WIDTH'(pTICK_DIV - 1);

  logic [pDIV_WIDTH-1:0] div_cnt;

  // Count 0 .. pTICK_DIV-1 and wrap; synchronous clear on reset
  always_ff @(posedge clk) begin
    if (!rst_n)                div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                       div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Phase sequencer for one approach: drives the down-counter's load/enable,
// reacts to its last flag, and adds a flashing-yellow night mode.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int pTICK_DIV   = 50_000_000,
  parameter int pDIV_WIDTH  = 26,
  parameter int pINIT_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   last,
  input  logic                   night_mode,
  output logic [pINIT_WIDTH-1:0] init,
  output logic                   en,
  output logic [2:0]             lights,
  output logic [1:0]             phase
);

  phase_t                 state_q, state_d;
  logic                   flash_q, flash_d;
  logic [pINIT_WIDTH-1:0] init_q, init_d;
  logic [2:0]             lights_q, lights_d;
  logic                   tick;

  tick_prescaler #(
    .pTICK_DIV (pTICK_DIV),
    .pDIV_WIDTH(pDIV_WIDTH)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // State, load pulse and lamp registers; reset reloads the green count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= GREEN;
      flash_q  <= 1'b0;
      init_q   <= pINIT_WIDTH'(LOAD_GREEN);
      lights_q <= LAMP_GREEN;
    end else begin
      state_q  <= state_d;
      flash_q  <= flash_d;
      init_q   <= init_d;
      lights_q <= lights_d;
    end
  end

  // Next-state logic: only a tick can move the FSM; the load pulse defaults to idle
  always_comb begin
    state_d = state_q;
    flash_d = flash_q;
    init_d  = '0;
    if (tick) begin
      case (state_q)
        GREEN: if (last) begin
          state_d = YELLOW;
          init_d  = pINIT_WIDTH'(LOAD_YELLOW);
        end
        YELLOW: if (last) begin
          state_d = RED;
          init_d  = pINIT_WIDTH'(LOAD_RED);
        end
        RED: if (last) begin
          // Night requests are honoured only here so a running cycle always completes
          if (night_mode) begin
            state_d = FLASH;
            flash_d = 1'b1;
          end else begin
            state_d = GREEN;
            init_d  = pINIT_WIDTH'(LOAD_GREEN);
          end
        end
        default: begin
          if (night_mode) begin
            flash_d = ~flash_q;
          end else begin
            state_d = GREEN;
            flash_d = 1'b0;
            init_d  = pINIT_WIDTH'(LOAD_GREEN);
          end
        end
      endcase
    end
    lights_d = lamp_code(state_d, flash_d);
  end

  // The counter is frozen while flashing
  assign en     = tick & (state_q != FLASH);
  assign init   = init_q;
  assign lights = lights_q;
  assign phase  = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl with a behavioural light_counter stand-in and a
// tick-level reference model of the phase sequence.
module tb_traffic_phase_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       night_mode = 1'b0;
  logic       last;
  logic [2:0] init;
  logic       en;
  logic [2:0] lights;
  logic [1:0] phase;

  // Counter stand-in (or a stub that forces last directly)
  int   cnt = 0;
  logic use_stub = 1'b0;
  logic stub_last = 1'b0;
  assign last = use_stub ? stub_last : (cnt == 0);

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .pTICK_DIV  (DIV),
    .pDIV_WIDTH (2),
    .pINIT_WIDTH(3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .last      (last),
    .night_mode(night_mode),
    .init      (init),
    .en        (en),
    .lights    (lights),
    .phase     (phase)
  );

  // Reference model: phase index, flash level, pending load, cycles since reset
  int         m_phase = 0;
  bit         m_flash = 1'b0;
  logic [2:0] m_init  = 3'b000;
  int         m_cyc   = 0;
  bit         m_valid = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [2:0] exp_lights(input int p, input bit f);
    case (p)
      0:       return 3'b001;
      1:       return 3'b010;
      2:       return 3'b100;
      default: return {1'b0, f, 1'b0};
    endcase
  endfunction

  function automatic int load_val(input logic [2:0] i);
    if (i == 3'b001) return 14;
    if (i == 3'b010) return 2;
    return 17;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  // One clock: compare at the falling edge, advance model and counter across the rising edge
  task automatic step();
    int         n_phase, n_cyc;
    bit         n_flash, tk;
    logic [2:0] n_init, cap_init;
    logic       cap_en;
    if (m_valid) begin
      tk = ((m_cyc % DIV) == DIV - 1);
      check("phase",  32'(phase),  32'(m_phase));
      check("lights", 32'(lights), 32'(exp_lights(m_phase, m_flash)));
      check("init",   32'(init),   32'(m_init));
      check("en",     32'(en),     32'(tk && m_phase != 3));
    end
    if (!rst_n) begin
      n_phase = 0; n_flash = 1'b0; n_init = 3'b001; n_cyc = 0;
    end else begin
      tk      = ((m_cyc % DIV) == DIV - 1);
      n_cyc   = m_cyc + 1;
      n_phase = m_phase;
      n_flash = m_flash;
      n_init  = 3'b000;
      if (tk) begin
        if (m_phase == 3) begin
          if (night_mode) n_flash = !m_flash;
          else begin n_phase = 0; n_init = 3'b001; end
        end else if (last) begin
          if (m_phase == 2 && night_mode) begin
            n_phase = 3; n_flash = 1'b1;
          end else begin
            n_phase = (m_phase + 1) % 3;
            n_init  = 3'(1 << n_phase);
          end
        end
      end
    end
    if (!rst_n) m_valid = 1'b1;
    cap_init = init;
    cap_en   = en;
    @(posedge clk);
    #1;
    m_phase = n_phase; m_flash = n_flash; m_init = n_init; m_cyc = n_cyc;
    if (cap_init === 3'b001 || cap_init === 3'b010 || cap_init === 3'b100) cnt = load_val(cap_init);
    else if (cap_en === 1'b1 && cnt > 0) cnt--;
    @(negedge clk);
  endtask

  int rec_y, rec_r, rec_g, bad;

  initial begin
    @(negedge clk);

    // Reset held 3 cycles, then release
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    check("rel_init",   32'(init),   32'h1);
    check("rel_lights", 32'(lights), 32'h1);
    check("rel_en",     32'(en),     32'h0);
    repeat (3) step();
    check("first_en_cycle3", 32'(en), 32'h1);
    step();
    check("cnt_after_first_tick", 32'(cnt), 32'd13);

    // Full period with night mode off
    rec_y = -1; rec_r = -1; rec_g = -1;
    for (int i = 0; i < 145; i++) begin
      if (init == 3'b010 && rec_y < 0) rec_y = m_cyc;
      if (init == 3'b100 && rec_r < 0) rec_r = m_cyc;
      if (init == 3'b001 && rec_g < 0) rec_g = m_cyc;
      step();
    end
    check("yellow_load_cycle", 32'(rec_y), 32'd60);
    check("red_load_cycle",    32'(rec_r), 32'd72);
    check("green_load_cycle",  32'(rec_g), 32'd144);

    // Night request raised mid-green
    for (int i = 0; i < 100 && !(phase == 2'd0 && cnt == 7); i++) step();
    check("wait_green7", 32'(cnt), 32'd7);
    night_mode = 1'b1;
    for (int i = 0; i < 200 && phase != 2'd3; i++) step();
    check("flash_phase",  32'(phase),  32'h3);
    check("flash_lights", 32'(lights), 32'h2);
    check("flash_init",   32'(init),   32'h0);
    repeat (4) step();
    check("flash_off", 32'(lights), 32'h0);
    repeat (4) step();
    check("flash_on", 32'(lights), 32'h2);

    // Leave FLASH
    night_mode = 1'b0;
    for (int i = 0; i < 8 && phase != 2'd0; i++) step();
    check("exit_phase",  32'(phase),  32'h0);
    check("exit_lights", 32'(lights), 32'h1);
    check("exit_init",   32'(init),   32'h1);
    step();
    check("exit_reload", 32'(cnt), 32'd14);

    // Reset at yellow count 1
    for (int i = 0; i < 200 && !(phase == 2'd1 && cnt == 1); i++) step();
    check("wait_yellow1", 32'(cnt), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("myr_phase",  32'(phase),  32'h0);
    check("myr_lights", 32'(lights), 32'h1);
    check("myr_init",   32'(init),   32'h1);
    check("myr_en",     32'(en),     32'h0);
    repeat (3) step();
    check("myr_en_cycle3", 32'(en), 32'h1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (init == 3'b010 || init == 3'b100) bad++;
      step();
    end
    check("myr_no_stray_load", 32'(bad), 32'd0);

    // last forced high on non-tick cycles must not move the FSM
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    use_stub  = 1'b1;
    stub_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stub_hold", 32'(phase), 32'h0);
    end
    check("stub_tick_en", 32'(en), 32'h1);
    step();
    check("stub_phase", 32'(phase), 32'h1);
    check("stub_init",  32'(init),  32'h2);
    use_stub  = 1'b0;
    stub_last = 1'b0;

    // Randomised night requests and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) night_mode = ~night_mode;
      rst_n = ($urandom_range(0, 699) != 0);
      step();
    end
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
